// File: rtl/frame_pair_ctrl.sv
// frame_pair_ctrl: buffers one frame of FRAME_LEN symbols in an external RAM, then
// streams it out as pairs (k, k+HALF) with a valid/ready handshake.
//   clk, rst                       : single clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      : input symbol stream (accepted only while filling)
//   out_valid/out_ready            : output pair handshake
//   out_a/out_b/out_last           : symbols k and k+HALF, out_last marks k=HALF-1
//   frame_done                     : pulse on the handshake of the final pair
//   ram_addrc/ram_dinc/ram_wec     : RAM write port (RAM captures on negedge clk)
//   ram_addra/ram_addrb/ram_ena/enb: RAM read ports; ram_douta/doutb return 1 posedge later
module frame_pair_ctrl #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 10,
    parameter int FRAME_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_a,
    output logic [DSIZE-1:0] out_b,
    output logic             out_last,
    output logic             frame_done,
    output logic [ASIZE-1:0] ram_addrc,
    output logic [DSIZE-1:0] ram_dinc,
    output logic             ram_wec,
    output logic [ASIZE-1:0] ram_addra,
    output logic [ASIZE-1:0] ram_addrb,
    output logic             ram_ena,
    output logic             ram_enb,
    input  logic [DSIZE-1:0] ram_douta,
    input  logic [DSIZE-1:0] ram_doutb
);
    localparam int HALF = FRAME_LEN / 2;
    localparam logic [ASIZE-1:0] LAST_WR = ASIZE'(FRAME_LEN - 1);
    localparam logic [ASIZE-1:0] LAST_RD = ASIZE'(HALF - 1);
    localparam logic [ASIZE-1:0] HALF_A  = ASIZE'(HALF);
    typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;
    state_t           state;
    logic [ASIZE-1:0] wr_cnt;
    logic [ASIZE-1:0] rd_cnt;
    logic             accept;
    logic             issue;
    // rst gates in_ready so nothing is accepted or written while reset is held
    assign in_ready   = (state == FILL) & ~rst;
    assign accept     = in_valid & in_ready;
    assign ram_wec    = accept;
    assign ram_addrc  = wr_cnt;
    assign ram_dinc   = in_data;
    // a new read is launched whenever the output register is empty or being consumed
    assign issue      = (state == DRAIN) & (~out_valid | out_ready);
    assign ram_ena    = issue;
    assign ram_enb    = issue;
    assign ram_addra  = rd_cnt;
    assign ram_addrb  = rd_cnt + HALF_A;
    // RAM read registers act as the output data register; they hold while enables are low
    assign out_a      = ram_douta;
    assign out_b      = ram_doutb;
    assign frame_done = (state == FLUSH) & out_valid & out_ready & out_last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= issue | (out_valid & ~out_ready);
            if (issue) out_last <= (rd_cnt == LAST_RD);
            case (state)
                FILL: if (accept) begin
                    wr_cnt <= (wr_cnt == LAST_WR) ? '0 : wr_cnt + 1'b1;
                    if (wr_cnt == LAST_WR) begin
                        rd_cnt <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: if (issue) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST_RD) state <= FLUSH;
                end
                FLUSH: if (frame_done) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_pair_ctrl.sv
// tb_frame_pair_ctrl: self-checking bench for frame_pair_ctrl with an 8-symbol frame.
module tb_frame_pair_ctrl;
    localparam int DSIZE = 8, ASIZE = 3, FRAME_LEN = 8, HALF = FRAME_LEN / 2;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [DSIZE-1:0] in_data = '0;
    logic             in_ready, out_valid, out_last, frame_done, ram_wec, ram_ena, ram_enb;
    logic [DSIZE-1:0] out_a, out_b, ram_dinc, ram_douta, ram_doutb;
    logic [ASIZE-1:0] ram_addrc, ram_addra, ram_addrb;
    always #5 clk = ~clk;
    frame_pair_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_last(out_last), .frame_done(frame_done), .ram_addrc(ram_addrc),
        .ram_dinc(ram_dinc), .ram_wec(ram_wec), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_ena(ram_ena), .ram_enb(ram_enb), .ram_douta(ram_douta), .ram_doutb(ram_doutb)
    );
    logic [DSIZE-1:0] mem [FRAME_LEN];
    always @(negedge clk) if (ram_wec) mem[ram_addrc] <= ram_dinc;
    always @(posedge clk) begin
        if (ram_ena) ram_douta <= mem[ram_addra];
        if (ram_enb) ram_doutb <= mem[ram_addrb];
    end
    int total = 0, bad = 0, done_cnt = 0;
    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endfunction
    // reference model: accepted symbols collect in acc; a full frame becomes a queue of
    // expected pairs; phase 0=accepting, 1=one dead cycle before the first pair, 2=presenting
    typedef struct {logic [7:0] a; logic [7:0] b; logic last;} pair_t;
    logic [7:0] acc[$];
    pair_t      pq[$];
    int         phase = 0;
    bit         chk_en = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0;
            acc.delete();
            pq.delete();
        end else if (phase == 0) begin
            if (in_valid) begin
                acc.push_back(in_data);
                if (acc.size() == FRAME_LEN) begin
                    for (int k = 0; k < HALF; k++) pq.push_back('{acc[k], acc[k+HALF], k == HALF-1});
                    acc.delete();
                    phase = 1;
                end
            end
        end else if (phase == 1) phase = 2;
        else if (out_ready) begin
            void'(pq.pop_front());
            if (pq.size() == 0) phase = 0;
        end
    end
    logic fill_e, en_e;
    int   nxt;
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (chk_en) begin
            fill_e = (phase == 0) && !rst;
            en_e   = (phase == 1) || (phase == 2 && out_ready && pq.size() > 1);
            chk("in_ready", in_ready, fill_e);
            chk("ram_wec", ram_wec, fill_e && in_valid);
            if (fill_e && in_valid) begin
                chk("ram_addrc", ram_addrc, acc.size());
                chk("ram_dinc", ram_dinc, in_data);
            end
            chk("out_valid", out_valid, phase == 2);
            chk("ram_ena", ram_ena, en_e);
            chk("ram_enb", ram_enb, en_e);
            if (en_e) begin
                nxt = (phase == 1) ? 0 : HALF - pq.size() + 1;
                chk("ram_addra", ram_addra, nxt);
                chk("ram_addrb", ram_addrb, nxt + HALF);
            end
            if (phase == 2) begin
                chk("out_a", out_a, pq[0].a);
                chk("out_b", out_b, pq[0].b);
                chk("out_last", out_last, pq[0].last);
            end
            chk("frame_done", frame_done, phase == 2 && out_ready && pq.size() == 1);
        end
    end
    task automatic step(logic iv, logic [7:0] d, logic rdy);
        in_valid = iv;
        in_data = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask
    task automatic send_frame(logic [7:0] base, bit toggle);
        int n = 0;
        logic v;
        for (int c = 0; n < FRAME_LEN && c < 40; c++) begin
            v = !toggle || (c % 2 == 0);
            step(v, 8'(base + n), 1'b1);
            if (v) n++;
        end
    endtask
    task automatic drain(bit stall, logic iv);
        int d0 = done_cnt;
        for (int c = 0; c < 40 && done_cnt == d0; c++)
            step(iv, 8'($urandom), !(stall && c >= 2 && c < 5));
        chk("drain_frame_done", done_cnt, d0 + 1);
    endtask
    typedef struct {
        logic iv; logic [7:0] d; logic rdy;
        logic e_ir, e_wec, e_ov; logic [7:0] e_a, e_b; logic e_last, e_done;
    } vec_t;
    vec_t tbl[14];
    initial begin
        for (int i = 0; i < FRAME_LEN; i++) tbl[i] = '{1, 8'(8'h10 + i), 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < HALF; k++)
            tbl[9+k] = '{0, 0, 1, 0, 0, 1, 8'(8'h10 + k), 8'(8'h14 + k), k == HALF-1, k == HALF-1};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wec_en", {ram_wec, ram_ena, ram_enb}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].iv;
            in_data = tbl[i].d;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_wec", i), ram_wec, tbl[i].e_wec);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_done", i), frame_done, tbl[i].e_done);
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_pair", i), {out_a, out_b, 7'd0, out_last},
                                 {tbl[i].e_a, tbl[i].e_b, 7'd0, tbl[i].e_last});
            @(posedge clk);
            #1;
        end
        send_frame(8'h10, 0);
        drain(1, 0);
        send_frame(8'h50, 1);
        drain(0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 1);
        rst = 1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_wec", ram_wec, 0);
        chk("midrst_out", {out_valid, out_last, frame_done, ram_ena}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_addrc", ram_addrc, 0);
        send_frame(8'h20, 0);
        drain(0, 0);
        send_frame(8'h30, 0);
        drain(0, 0);
        chk("b2b_in_ready", in_ready, 1);
        send_frame(8'h40, 0);
        drain(0, 0);
        for (int i = 0; i < 800; i++) step(1'($urandom), 8'($urandom), ($urandom % 4) != 0);
        for (int i = 0; i < 40 && phase != 0; i++) step(0, 0, 1);
        chk("final_phase_fill", in_ready, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
